burst_sram_ctrl: RTL and testbench

Parametrised burst memory controller. Accepts one burst request at a time (FIXED, INCR or WRAP), generates per-beat addresses with programmable stride, and performs write or read beats on an internal single-port SRAM array. It is the successor to the stride-only address-generator-plus-SRAM pair, adding burst length, burst modes, request/beat handshakes and a completion indication.

---
 rtl/burst_sram_ctrl_if.sv | 36 +++
 rtl/burst_sram_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_burst_sram_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_sram_ctrl_if.sv
// Bus interface for burst_sram_ctrl: request channel, write beat channel,
// read beat channel and completion/error strobes.
interface burst_sram_ctrl_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int LEN_WIDTH    = 4,
    parameter int STRIDE_WIDTH = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [1:0]              req_mode;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [LEN_WIDTH-1:0]    req_len;
    logic [STRIDE_WIDTH-1:0] req_stride;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic                    rd_last;
    logic                    done;
    logic                    err;

    modport master (
        output req_valid, req_write, req_mode, req_addr, req_len, req_stride,
        output wr_data, wr_valid,
        input  req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err
    );

    modport slave (
        input  req_valid, req_write, req_mode, req_addr, req_len, req_stride,
        input  wr_data, wr_valid,
        output req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err
    );
endinterface

// File: rtl/burst_sram_ctrl.sv
// Burst SRAM controller: accepts one FIXED/INCR/WRAP burst at a time, walks
// the beat addresses with a running address register and performs write or
// read beats on an internal single-port array. Read data is registered, so
// each read beat appears one cycle after its address is issued.
// Optional: define BURST_BOUNDARY_ERR_EN to reject INCR bursts that would run
// past the top of the array (err pulse, no access); otherwise INCR wraps.
module burst_sram_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int LEN_WIDTH    = 4,
    parameter int STRIDE_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    burst_sram_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] MODE_FIXED = 2'b00;
    localparam logic [1:0] MODE_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t state;
    state_t next_state;

    // Burst context latched on accept
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] step_r;
    logic [ADDR_WIDTH-1:0] mask_r;
    logic                  wrap_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  beat_cnt;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic accept;
    logic reject;
    logic advance;
    logic last_beat;
    logic mem_we;
    logic mem_re;
    logic req_ready_c;
    logic wr_ready_c;
    logic done_c;

    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;
    logic                  last_p1;
    logic                  err_p1;

    // Zero-extend (or truncate) the length field into an address-wide mask
    function automatic logic [ADDR_WIDTH-1:0] len_to_mask(input logic [LEN_WIDTH-1:0] len);
        logic [ADDR_WIDTH+LEN_WIDTH-1:0] ext;
        ext = {{ADDR_WIDTH{1'b0}}, len};
        return ext[ADDR_WIDTH-1:0];
    endfunction

    // Zero-extend (or truncate) the stride into an address-wide increment
    function automatic logic [ADDR_WIDTH-1:0] stride_to_step(input logic [STRIDE_WIDTH-1:0] stride);
        logic [ADDR_WIDTH+STRIDE_WIDTH-1:0] ext;
        ext = {{ADDR_WIDTH{1'b0}}, stride};
        return ext[ADDR_WIDTH-1:0];
    endfunction

    // True when beats = len+1 is a power of two of at least 2
    function automatic logic is_wrap_len(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] nxt;
        nxt = len + 1'b1;
        return (len != '0) && ((len & nxt) == '0);
    endfunction

    // Next beat address: wrap the low field inside the aligned window, or add the step
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [ADDR_WIDTH-1:0] step,
        input logic [ADDR_WIDTH-1:0] mask,
        input logic                  wrap
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] res;
        inc = addr + 1'b1;
        if (wrap) begin
            res = (addr & ~mask) | (inc & mask);
        end else begin
            res = addr + step;
        end
        return res;
    endfunction

`ifdef BURST_BOUNDARY_ERR_EN
    localparam int CHK_W = ADDR_WIDTH + LEN_WIDTH + STRIDE_WIDTH;

    logic [CHK_W-1:0] last_addr_ext;
    logic             incr_req;

    // Only modes 01 and 11 walk with the stride; bit 0 identifies them
    assign incr_req      = bus.req_mode[0];
    assign last_addr_ext = {{(LEN_WIDTH+STRIDE_WIDTH){1'b0}}, bus.req_addr}
                         + ({{(ADDR_WIDTH+STRIDE_WIDTH){1'b0}}, bus.req_len}
                          * {{(ADDR_WIDTH+LEN_WIDTH){1'b0}}, bus.req_stride});
    assign reject = (state == IDLE) && bus.req_valid && incr_req
                 && ((last_addr_ext >> ADDR_WIDTH) != '0);
`else
    assign reject = 1'b0;
`endif

    assign accept    = (state == IDLE) && bus.req_valid && !reject;
    assign last_beat = (beat_cnt == len_r);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, handshake strobes and array enables
    always_comb begin
        next_state  = state;
        req_ready_c = 1'b0;
        wr_ready_c  = 1'b0;
        done_c      = 1'b0;
        advance     = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        case (state)
            IDLE: begin
                req_ready_c = 1'b1;
                if (accept) begin
                    next_state = bus.req_write ? WRITE : READ;
                end
            end
            WRITE: begin
                wr_ready_c = 1'b1;
                if (bus.wr_valid) begin
                    mem_we  = 1'b1;
                    advance = 1'b1;
                    if (last_beat) begin
                        next_state = DONE;
                    end
                end
            end
            READ: begin
                mem_re  = 1'b1;
                advance = 1'b1;
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Beat counter: cleared on accept, stepped once per performed beat
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= '0;
        end else if (advance) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Burst context capture and running address update
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_r <= bus.req_addr;
            len_r  <= bus.req_len;
            mask_r <= len_to_mask(bus.req_len);
            wrap_r <= (bus.req_mode == MODE_WRAP) && is_wrap_len(bus.req_len);
            if (bus.req_mode == MODE_FIXED) begin
                step_r <= '0;
            end else if (bus.req_mode == MODE_WRAP) begin
                step_r <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                step_r <= stride_to_step(bus.req_stride);
            end
        end else if (advance) begin
            addr_r <= next_addr(addr_r, step_r, mask_r, wrap_r);
        end
    end

    // Array write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_r] <= bus.wr_data;
        end
    end

    // Stage p1: registered read data with its valid/last and the error strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            err_p1     <= 1'b0;
        end else begin
            vld_p1  <= mem_re;
            last_p1 <= mem_re && last_beat;
            err_p1  <= reject;
            if (mem_re) begin
                rd_data_p1 <= mem[addr_r];
            end
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.wr_ready  = wr_ready_c;
    assign bus.done      = done_c;
    assign bus.rd_data   = rd_data_p1;
    assign bus.rd_valid  = vld_p1;
    assign bus.rd_last   = last_p1;
    assign bus.err       = err_p1;
endmodule

// File: tb/tb_burst_sram_ctrl.sv
// Directed testbench for burst_sram_ctrl: burst writes followed by read-back
// bursts, compared against hand-computed word sequences.
module tb_burst_sram_ctrl;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = 4;
    localparam int SW = 4;

    localparam int M_FIXED = 0;
    localparam int M_INCR  = 1;
    localparam int M_WRAP  = 2;
    localparam int M_RSVD  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    burst_sram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)) bus ();

    burst_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int last_cnt = 0;

    logic [31:0] rd_q  [$];
    logic [31:0] exp_q [$];
    logic [31:0] wq    [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observe outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (bus.rd_valid) rd_q.push_back(bus.rd_data);
        if (bus.rd_last)  last_cnt++;
        if (bus.done)     done_cnt++;
        if (bus.err)      err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    task automatic send_req(input int w, input int m, input int a, input int l, input int s);
        check("req_ready", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w[0];
        bus.req_mode   = 2'(m);
        bus.req_addr   = 8'(a);
        bus.req_len    = 4'(l);
        bus.req_stride = 4'(s);
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic write_burst(input int m, input int a, input int l, input int s,
                               input int stall_beat, input int stall_n);
        int d0;
        d0 = done_cnt;
        send_req(1, m, a, l, s);
        for (int b = 0; b <= l; b++) begin
            if (b == stall_beat) begin
                bus.wr_valid = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    check("wr_stall_done", bus.done, 0);
                    check("wr_stall_ready", bus.wr_ready, 1);
                    tick();
                end
            end
            bus.wr_data  = wq[b];
            bus.wr_valid = 1'b1;
            check("wr_ready", bus.wr_ready, 1);
            tick();
        end
        bus.wr_valid = 1'b0;
        check("wr_done", bus.done, 1);
        check("wr_no_early_done", done_cnt - d0, 0);
        tick();
        check("wr_idle_ready", bus.req_ready, 1);
        check("wr_done_once", done_cnt - d0, 1);
    endtask

    task automatic read_burst(input int m, input int a, input int l, input int s);
        int d0;
        int l0;
        d0 = done_cnt;
        l0 = last_cnt;
        rd_q.delete();
        send_req(0, m, a, l, s);
        check("rd_lat0", bus.rd_valid, 0);
        tick();
        check("rd_lat1", bus.rd_valid, 1);
        repeat (l) tick();
        check("rd_done", bus.done, 1);
        check("rd_last", bus.rd_last, 1);
        tick();
        check("rd_idle_ready", bus.req_ready, 1);
        check("rd_idle_valid", bus.rd_valid, 0);
        check("rd_beats", rd_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rd_data[%0d]", i), (i < rd_q.size()) ? rd_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        end
        check("rd_last_once", last_cnt - l0, 1);
        check("rd_done_once", done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_mode   = 2'b00;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        bus.req_stride = '0;
        bus.wr_data    = '0;
        bus.wr_valid   = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_last", bus.rd_last, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rd_data", bus.rd_data, 0);
        rst = 1'b0;
        tick();
        check("rel_req_ready", bus.req_ready, 1);

        // Prefill 0x08..0x17 with 0x100+addr
        wq.delete();
        for (int i = 0; i < 16; i++) wq.push_back(32'h108 + i);
        write_burst(M_INCR, 8'h08, 15, 1, -1, 0);

        // INCR stride 2 write then read back
        wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        write_burst(M_INCR, 8'h10, 3, 2, -1, 0);
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        read_burst(M_INCR, 8'h10, 3, 2);
        exp_q = '{32'hA0, 32'h111, 32'hA1, 32'h113, 32'hA2, 32'h115, 32'hA3, 32'h117};
        read_burst(M_INCR, 8'h10, 7, 1);

        // WRAP: 4 beats wrap inside 0x0C..0x0F; 3 beats fall back to INCR stride 1
        exp_q = '{32'h10E, 32'h10F, 32'h10C, 32'h10D};
        read_burst(M_WRAP, 8'h0E, 3, 5);
        exp_q = '{32'h10E, 32'h10F, 32'hA0};
        read_burst(M_WRAP, 8'h0E, 2, 5);

        // FIXED write of 8 beats with a 2-cycle stall before beat 4
        wq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        write_burst(M_FIXED, 8'h20, 7, 3, 4, 2);
        exp_q = '{32'd8};
        read_burst(M_FIXED, 8'h20, 0, 0);
        exp_q = '{32'd8, 32'd8, 32'd8};
        read_burst(M_FIXED, 8'h20, 2, 7);

        // Top-of-array INCR burst
        wq = '{32'hE0, 32'hE1};
        write_burst(M_INCR, 8'hFE, 1, 1, -1, 0);
        wq = '{32'hE2, 32'hE3};
        write_burst(M_INCR, 8'h00, 1, 1, -1, 0);
`ifdef BURST_BOUNDARY_ERR_EN
        d0 = err_cnt;
        send_req(1, M_INCR, 8'hFE, 3, 1);
        check("bnd_err", bus.err, 1);
        check("bnd_req_ready", bus.req_ready, 1);
        check("bnd_wr_ready", bus.wr_ready, 0);
        tick();
        check("bnd_err_pulse", bus.err, 0);
        check("bnd_err_once", err_cnt - d0, 1);
        exp_q = '{32'hE0, 32'hE1};
        read_burst(M_INCR, 8'hFE, 1, 1);
        exp_q = '{32'hE2, 32'hE3};
        read_burst(M_INCR, 8'h00, 1, 1);
`else
        wq = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
        write_burst(M_INCR, 8'hFE, 3, 1, -1, 0);
        check("no_err", err_cnt, 0);
        exp_q = '{32'hF0, 32'hF1};
        read_burst(M_INCR, 8'hFE, 1, 1);
        exp_q = '{32'hF2, 32'hF3};
        read_burst(M_INCR, 8'h00, 1, 1);
        exp_q = '{32'hF0, 32'hF1, 32'hF2, 32'hF3};
        read_burst(M_RSVD, 8'hFE, 3, 1);
`endif

        // Reset during beat 2 of a 6-beat read
        d0 = done_cnt;
        send_req(0, M_INCR, 8'h08, 5, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_rd_valid", bus.rd_valid, 0);
        check("mid_rst_done", bus.done, 0);
        rst = 1'b0;
        tick();
        check("mid_rst_req_ready", bus.req_ready, 1);
        check("mid_rst_rd_valid2", bus.rd_valid, 0);
        check("mid_rst_no_done", done_cnt - d0, 0);
        exp_q = '{32'h108, 32'h109};
        read_burst(M_INCR, 8'h08, 1, 1);

        // Back-to-back requests with req_valid held high
        d0 = done_cnt;
        rd_q.delete();
        check("b2b_ready0", bus.req_ready, 1);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_mode   = 2'b01;
        bus.req_addr   = 8'h10;
        bus.req_len    = 4'd1;
        bus.req_stride = 4'd2;
        tick();
        bus.req_mode   = 2'b00;
        bus.req_addr   = 8'h20;
        bus.req_len    = 4'd0;
        bus.req_stride = 4'd0;
        check("b2b_busy0", bus.req_ready, 0);
        tick();
        check("b2b_busy1", bus.req_ready, 0);
        tick();
        check("b2b_done1", bus.done, 1);
        check("b2b_done_busy", bus.req_ready, 0);
        tick();
        check("b2b_idle_ready", bus.req_ready, 1);
        check("b2b_idle_done", bus.done, 0);
        tick();
        bus.req_valid = 1'b0;
        check("b2b_accepted", bus.req_ready, 0);
        tick();
        check("b2b_done2", bus.done, 1);
        tick();
        check("b2b_final_ready", bus.req_ready, 1);
        check("b2b_beats", rd_q.size(), 3);
        check("b2b_data0", (rd_q.size() > 0) ? rd_q[0] : 32'hDEAD_BEEF, 32'hA0);
        check("b2b_data1", (rd_q.size() > 1) ? rd_q[1] : 32'hDEAD_BEEF, 32'hA1);
        check("b2b_data2", (rd_q.size() > 2) ? rd_q[2] : 32'hDEAD_BEEF, 32'd8);
        check("b2b_done_cnt", done_cnt - d0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
